// File: rtl/wb_initiator.sv
// Single-transfer Wishbone classic initiator: one command in, one bus cycle out,
// one response back, with an optional strobe timeout that aborts a silent slave.
module wb_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // An 8-bit saturating counter can never reach a limit beyond 256 cycles,
    // so such settings behave like a disabled timeout.
    localparam bit         TO_EN   = (TIMEOUT > 0) && (TIMEOUT <= 256);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'hFF;

    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // Ack is tested first so it wins a same-cycle timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator (TIMEOUT=4): directed scenarios plus randomized
// transfers checked against an outcome model derived from ack timing.
module tb_wb_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, dato;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic [31:0] dati = '0;

    int checks = 0, errors = 0;

    wb_initiator #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_sel_o(sel),
        .wbm_ack_i(ack), .wbm_dat_i(dati)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          stb_n;
        logic [31:0] dat;
        logic        err;
        bit          outs_ok;
        bit          stable;
        int          vld_n;
        logic        vld_after;
        logic        rdy_after;
        bit          bound_hit;
    } obs_t;

    // Drives one command, plays the slave (ack in BUS cycle ack_at, 0 = never),
    // holds rsp_ready low for wait_n cycles with stray acks, then consumes.
    task automatic do_txn(input logic we_i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int ack_at, input logic [31:0] rd,
                          input int wait_n, output obs_t o);
        o = '{stb_n: 0, dat: '0, err: 1'b0, outs_ok: 1'b1, stable: 1'b1,
              vld_n: 0, vld_after: 1'b0, rdy_after: 1'b0, bound_hit: 1'b0};
        cmd_valid = 1'b1; cmd_we = we_i; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        tick;
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        for (int k = 1; k <= 300 && stb; k++) begin
            o.stb_n++;
            if (!(cyc && we === we_i && adr === a && dato === d && sel === s && !cmd_ready))
                o.outs_ok = 1'b0;
            ack  = (k == ack_at);
            dati = (k == ack_at) ? rd : $urandom;
            tick;
        end
        ack = 1'b0;
        if (stb) begin
            o.bound_hit = 1'b1;
            return;
        end
        o.dat = rsp_dat; o.err = rsp_err;
        for (int i = 0; i < wait_n; i++) begin
            if (rsp_valid) o.vld_n++;
            if (rsp_dat !== o.dat || rsp_err !== o.err || cyc || stb) o.stable = 1'b0;
            ack = 1'($urandom); dati = $urandom;
            tick;
        end
        ack = 1'b0;
        if (rsp_dat !== o.dat || rsp_err !== o.err || !rsp_valid) o.stable = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        o.vld_after = rsp_valid;
        o.rdy_after = cmd_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, stb, we, adr, dato, sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b dat=%h err=%b cyc=%b stb=%b adr=%h want all 0",
                     cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, stb, adr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rdy_before_edge got %b want 0", cmd_ready);
        end
        tick;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_rdy_first_edge got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write;
        obs_t o;
        do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'hFFFF_FFFF, 1, o);
        checks++;
        if (o.bound_hit || o.stb_n != 2 || !o.outs_ok) begin
            errors++; $display("FAIL write_burst got stb_n=%0d outs_ok=%0b want 2 1", o.stb_n, o.outs_ok);
        end
        checks++;
        if (o.dat !== 32'h0 || o.err !== 1'b0 || !o.stable || o.vld_n != 1) begin
            errors++; $display("FAIL write_rsp got dat=%h err=%b vld_n=%0d want 0 0 1", o.dat, o.err, o.vld_n);
        end
        checks++;
        if (o.vld_after !== 1'b0 || o.rdy_after !== 1'b1) begin
            errors++; $display("FAIL write_exit got vld=%b rdy=%b want 0 1", o.vld_after, o.rdy_after);
        end
    endtask

    task automatic test_read;
        obs_t o;
        do_txn(1'b0, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, 1, 32'h1234_5678, 4, o);
        checks++;
        if (o.bound_hit || o.stb_n != 1 || !o.outs_ok) begin
            errors++; $display("FAIL read_burst got stb_n=%0d outs_ok=%0b want 1 1", o.stb_n, o.outs_ok);
        end
        checks++;
        if (o.dat !== 32'h1234_5678 || o.err !== 1'b0) begin
            errors++; $display("FAIL read_data got dat=%h err=%b want 12345678 0", o.dat, o.err);
        end
        checks++;
        if (o.vld_n != 4 || !o.stable || o.vld_after !== 1'b0) begin
            errors++; $display("FAIL read_hold got vld_n=%0d stable=%0b after=%b want 4 1 0",
                               o.vld_n, o.stable, o.vld_after);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        do_txn(1'b0, 32'h4000_0010, 32'h0, 4'h3, 0, 32'h0, 3, o);
        checks++;
        if (o.bound_hit || o.stb_n != TO) begin
            errors++; $display("FAIL timeout_stb got stb_n=%0d want %0d", o.stb_n, TO);
        end
        checks++;
        if (o.err !== 1'b1 || o.dat !== 32'h0 || !o.stable) begin
            errors++; $display("FAIL timeout_rsp got err=%b dat=%h stable=%0b want 1 0 1", o.err, o.dat, o.stable);
        end
    endtask

    task automatic test_race;
        obs_t o;
        do_txn(1'b0, 32'h5000_0000, 32'h0, 4'h1, TO, 32'h0000_00A5, 0, o);
        checks++;
        if (o.bound_hit || o.stb_n != TO || o.err !== 1'b0 || o.dat !== 32'h0000_00A5) begin
            errors++; $display("FAIL race got stb_n=%0d err=%b dat=%h want %0d 0 a5", o.stb_n, o.err, o.dat, TO);
        end
    endtask

    // Outcome model: ack in BUS cycle n completes if n <= TIMEOUT, else the
    // transfer aborts after TIMEOUT strobe cycles.
    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            obs_t        o;
            logic        rw   = 1'($urandom);
            logic [31:0] a    = $urandom, d = $urandom, rd = $urandom;
            logic [3:0]  s    = 4'($urandom);
            int          n    = int'($urandom_range(0, TO + 2));
            int          wt   = int'($urandom_range(0, 3));
            bit          ok   = (n != 0) && (n <= TO);
            int          e_stb = ok ? n : TO;
            logic [31:0] e_dat = (ok && !rw) ? rd : 32'h0;
            do_txn(rw, a, d, s, n, rd, wt, o);
            checks++;
            if (o.bound_hit || o.stb_n != e_stb || !o.outs_ok || o.err !== !ok || o.dat !== e_dat
                || !o.stable || o.vld_n != wt || o.vld_after !== 1'b0 || o.rdy_after !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d got stb_n=%0d err=%b dat=%h outs=%0b stable=%0b vld_n=%0d want %0d %b %h 1 1 %0d",
                         t, o.stb_n, o.err, o.dat, o.outs_ok, o.stable, o.vld_n, e_stb, !ok, e_dat, wt);
            end
        end
    endtask

    // cmd_valid, rsp_ready and ack all held high: accept every third edge.
    task automatic test_back_to_back;
        logic [31:0] a_prev;
        bit          bad = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; rsp_ready = 1'b1;
        ack = 1'b1; dati = 32'h0000_0055;
        cmd_adr = $urandom;
        for (int i = 0; i < 12; i++) begin
            a_prev = cmd_adr;
            tick;
            cmd_adr = $urandom;
            if (i == 11) cmd_valid = 1'b0;
            if (stb !== (i % 3 == 0) || rsp_valid !== (i % 3 == 1) || cmd_ready !== (i % 3 == 2))
                bad = 1'b1;
            if (i % 3 == 0 && adr !== a_prev) bad = 1'b1;
            if (i % 3 == 1 && (rsp_dat !== 32'h55 || rsp_err !== 1'b0)) bad = 1'b1;
            if (bad) begin
                $display("FAIL b2b_cycle_%0d got stb=%b vld=%b rdy=%b adr=%h want %0b %0b %0b %h",
                         i, stb, rsp_valid, cmd_ready, adr, i % 3 == 0, i % 3 == 1, i % 3 == 2, a_prev);
                break;
            end
        end
        checks++;
        if (bad) errors++;
        ack = 1'b0; rsp_ready = 1'b0;
        tick;
        checks++;
        if (cmd_ready !== 1'b1 || stb !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got rdy=%b stb=%b vld=%b want 1 0 0", cmd_ready, stb, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_bus;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h6000_0000; cmd_dat = 32'h1; cmd_sel = 4'hF;
        tick;
        cmd_valid = 1'b0;
        tick;
        checks++;
        if (stb !== 1'b1 || cyc !== 1'b1) begin
            errors++; $display("FAIL midbus_pre got cyc=%b stb=%b want 1 1", cyc, stb);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL midbus_async got cyc=%b stb=%b vld=%b rdy=%b want 0 0 0 0",
                               cyc, stb, rsp_valid, cmd_ready);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || stb !== 1'b0) begin
            errors++; $display("FAIL midbus_release got rdy=%b vld=%b stb=%b want 1 0 0", cmd_ready, rsp_valid, stb);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_race;
        test_random;
        test_back_to_back;
        test_reset_mid_bus;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: number of strobe cycles without ack before abort; 0 disables the timeout.
REQ-002 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr  in  32  byte address.
REQ-008 SHALL have port cmd_dat  in  32  write data.
REQ-009 SHALL have port cmd_sel  in  4  byte lane selects.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_dat  out  32  read data.
REQ-013 SHALL have port rsp_err  out  1  1 = transaction aborted by timeout.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-015 SHALL have ports wbm_adr_o  out  32, wbm_dat_o  out  32 and wbm_sel_o  out  4  Wishbone master address, data and selects.
REQ-016 SHALL have ports wbm_ack_i  in  1 and wbm_dat_i  in  32  slave acknowledge and read data.

Function
REQ-017 SHALL implement the three states IDLE, BUS and RESP.
REQ-018 IDLE SHALL drive cmd_ready=1; in every other state cmd_ready SHALL be 0.
REQ-019 IDLE with cmd_valid=1 SHALL register cmd_we, cmd_adr, cmd_dat and cmd_sel into the wbm_* outputs, clear the timeout counter and enter BUS on the same edge.
REQ-020 BUS SHALL drive wbm_cyc_o=wbm_stb_o=1, with the registered wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o held stable for the whole state.
REQ-021 In BUS, wbm_ack_i=1 SHALL capture rsp_dat=wbm_dat_i on a read (0 on a write), set rsp_err=0 and enter RESP; cyc and stb SHALL deassert on that same edge, so each single transfer lasts exactly one ack.
REQ-022 In BUS with TIMEOUT>0, the counter SHALL increment every cycle without ack; the cycle in which the counter equals TIMEOUT-1 with no ack SHALL enter RESP with rsp_err=1 and rsp_dat=0, and cyc/stb SHALL deassert.
REQ-023 If ack and timeout coincide in the same cycle, ack SHALL win and rsp_err SHALL be 0.
REQ-024 The timeout counter SHALL be 8 bits wide and saturating; with TIMEOUT=0 it SHALL never abort.
REQ-025 RESP SHALL hold rsp_valid=1 with rsp_dat and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-026 A new command SHALL be accepted no earlier than the cycle after RESP exits; minimum command-to-command spacing is 3 cycles.
REQ-027 wbm_ack_i asserted outside BUS SHALL be ignored, with no state or data change.
REQ-028 cmd_* changes outside the IDLE accept cycle SHALL have no effect.

Reset
REQ-029 Asserting wb_rst_n=0 SHALL immediately force state IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, counter=0 and cmd_ready=0.
REQ-030 After reset deasserts, cmd_ready SHALL rise at the first clock edge.
REQ-031 Reset asserted during BUS SHALL drop cyc/stb asynchronously, discard the transaction and produce no response.

Verification
REQ-032 Write: cmd adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, we=1; slave acks in the 2nd BUS cycle -> one cyc/stb burst of 2 cycles with matching outputs, then rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-033 Read: adr=0x3000_0000; slave returns 0x1234_5678 with ack in the 1st BUS cycle -> rsp_dat=0x1234_5678, rsp_err=0; rsp_valid held 4 cycles while rsp_ready=0, then cleared on the rsp_ready edge.
REQ-034 Timeout: TIMEOUT=4, slave never acks -> stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0; a late ack after abort is ignored.
REQ-035 Race: TIMEOUT=4, ack arrives in the 4th BUS cycle with dat 0xA5 -> rsp_err=0, rsp_dat=0xA5.
REQ-036 Reset mid-BUS: wb_rst_n low in the 2nd BUS cycle -> cyc/stb go 0 without waiting for a clock edge, no rsp_valid, and cmd_ready=1 one edge after release.
REQ-037 Back-to-back: cmd_valid held high with rsp_ready=1 and immediate ack -> commands accepted every 3 cycles, and stray acks between transfers have no effect.
